reg_bus_arb: RTL and testbench

- Shares one downstream register bus between N_REQ upstream masters, e.g. host bridge and sequencer, feeding a single bus splitter.
- Captures each master's one-cycle WREN/RDEN pulses into per-master pending slots so simultaneous accesses are never lost.
- Issues pending accesses one at a time in round-robin order.
- Routes each read response back to the master that issued the read, with a timeout for unanswered reads.

---
 rtl/reg_bus_arb_pkg.sv | 25 ++
 rtl/reg_bus_arb_if.sv | 40 ++++
 rtl/reg_bus_arb_slot.sv | 68 ++++++
 rtl/reg_bus_arb.sv | 182 ++++++++++++++++++
 tb/tb_reg_bus_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_arb_pkg.sv
// Shared definitions for the register-bus arbiter.
// Holds the arbiter state encoding, the bus widths, the default read-timeout
// data word and a small modular-increment helper used by the round-robin
// search and pointer update.
package reg_bus_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam logic [DAT_W-1:0] TO_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2,
        ST_WAIT_RD  = 2'd3
    } arb_state_e;

    // (base + off) modulo n, used to walk the masters with wrap-around
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        wrap_add = (base + off) % n;
    endfunction

endpackage

// File: rtl/reg_bus_arb_if.sv
// Bus interfaces around the arbiter.
// reg_bus_req_if : upstream side, N_REQ masters packed 32 bits per master.
//   master modport = an upstream master group, slave modport = the arbiter.
// reg_bus_m_if   : downstream register bus towards the bus splitter.
//   master modport = the arbiter, slave modport = the splitter.
interface reg_bus_req_if #(parameter int N_REQ = 2);
    import reg_bus_pkg::*;

    logic [N_REQ-1:0]       REQ_WREN;
    logic [N_REQ-1:0]       REQ_RDEN;
    logic [ADR_W*N_REQ-1:0] REQ_WADR;
    logic [ADR_W*N_REQ-1:0] REQ_RADR;
    logic [DAT_W*N_REQ-1:0] REQ_WDAT;
    logic [DAT_W*N_REQ-1:0] REQ_RDAT;
    logic [N_REQ-1:0]       REQ_RVLD;
    logic [N_REQ-1:0]       REQ_WBUSY;
    logic [N_REQ-1:0]       REQ_RBUSY;

    modport master (output REQ_WREN, REQ_RDEN, REQ_WADR, REQ_RADR, REQ_WDAT,
                    input  REQ_RDAT, REQ_RVLD, REQ_WBUSY, REQ_RBUSY);
    modport slave  (input  REQ_WREN, REQ_RDEN, REQ_WADR, REQ_RADR, REQ_WDAT,
                    output REQ_RDAT, REQ_RVLD, REQ_WBUSY, REQ_RBUSY);
endinterface

interface reg_bus_m_if;
    import reg_bus_pkg::*;

    logic             M_WREN;
    logic             M_RDEN;
    logic [ADR_W-1:0] M_WADR;
    logic [ADR_W-1:0] M_RADR;
    logic [DAT_W-1:0] M_WDAT;
    logic [DAT_W-1:0] M_RDAT;
    logic             M_RVLD;

    modport master (output M_WREN, M_RDEN, M_WADR, M_RADR, M_WDAT,
                    input  M_RDAT, M_RVLD);
    modport slave  (input  M_WREN, M_RDEN, M_WADR, M_RADR, M_WDAT,
                    output M_RDAT, M_RVLD);
endinterface

// File: rtl/reg_bus_arb_slot.sv
// One master's pending-access holding slots (one write, one read).
// Ports: clk/rst (sync active-high); wren/rden pulses with wadr/wdat/radr;
// wr_take/rd_take from the arbiter empty a slot; wfull/rfull report occupancy;
// wadr_q/wdat_q/radr_q present the held access; ovf is a sticky drop flag.
module reg_bus_arb_slot
    import reg_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic             rden,
    input  logic [ADR_W-1:0] wadr,
    input  logic [ADR_W-1:0] radr,
    input  logic [DAT_W-1:0] wdat,
    input  logic             wr_take,
    input  logic             rd_take,
    output logic             wfull,
    output logic             rfull,
    output logic [ADR_W-1:0] wadr_q,
    output logic [ADR_W-1:0] radr_q,
    output logic [DAT_W-1:0] wdat_q,
    output logic             ovf
);

    logic             wfull_r, rfull_r, ovf_r;
    logic [ADR_W-1:0] wadr_r, radr_r;
    logic [DAT_W-1:0] wdat_r;
    logic             w_drop_s, r_drop_s;

    // A pulse is lost only when its slot stays full through this edge
    assign w_drop_s = wren && wfull_r && !wr_take;
    assign r_drop_s = rden && rfull_r && !rd_take;

    // Slot capture / consume / overflow bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wfull_r <= 1'b0;
            rfull_r <= 1'b0;
            ovf_r   <= 1'b0;
            wadr_r  <= '0;
            wdat_r  <= '0;
            radr_r  <= '0;
        end else begin
            if (wren && (!wfull_r || wr_take)) begin
                wfull_r <= 1'b1;
                wadr_r  <= wadr;
                wdat_r  <= wdat;
            end else if (wr_take) begin
                wfull_r <= 1'b0;
            end
            if (rden && (!rfull_r || rd_take)) begin
                rfull_r <= 1'b1;
                radr_r  <= radr;
            end else if (rd_take) begin
                rfull_r <= 1'b0;
            end
            ovf_r <= ovf_r | w_drop_s | r_drop_s;
        end
    end

    assign wfull  = wfull_r;
    assign rfull  = rfull_r;
    assign wadr_q = wadr_r;
    assign wdat_q = wdat_r;
    assign radr_q = radr_r;
    assign ovf    = ovf_r;

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter sharing one downstream register bus among N_REQ masters.
// Ports: CLK, RST (sync active-high); req (upstream masters, slave modport);
// m (downstream bus, master modport); OVF_STKY per-master dropped-pulse flag;
// TO_STKY set once any read has timed out.
module reg_bus_arb
    import reg_bus_pkg::*;
#(
    parameter int               N_REQ   = 2,
    parameter int               TIMEOUT = 64,
    parameter logic [DAT_W-1:0] TO_DATA = TO_DATA_DEF
)(
    input  logic             CLK,
    input  logic             RST,
    reg_bus_req_if.slave     req,
    reg_bus_m_if.master      m,
    output logic [N_REQ-1:0] OVF_STKY,
    output logic             TO_STKY
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_e       state_r, state_nxt_s;
    logic [IDX_W-1:0] ptr_r, gnt_r, sel_idx_s, cand_s;
    logic             sel_found_s, sel_wr_s, to_last_s;
    logic [CNT_W-1:0] to_cnt_r;

    logic [N_REQ-1:0] wfull_s, rfull_s, wr_take_s, rd_take_s, ovf_s;
    logic [ADR_W-1:0] slot_wadr_s [N_REQ];
    logic [ADR_W-1:0] slot_radr_s [N_REQ];
    logic [DAT_W-1:0] slot_wdat_s [N_REQ];

    logic             m_wren_r, m_rden_r, to_stky_r;
    logic [ADR_W-1:0] m_wadr_r, m_radr_r;
    logic [DAT_W-1:0] m_wdat_r;
    logic [DAT_W-1:0] rdat_r [N_REQ];
    logic [N_REQ-1:0] rvld_r;
    logic [DAT_W*N_REQ-1:0] rdat_pk_s;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slot
        reg_bus_arb_slot u_slot (
            .clk     (CLK),
            .rst     (RST),
            .wren    (req.REQ_WREN[k]),
            .rden    (req.REQ_RDEN[k]),
            .wadr    (req.REQ_WADR[ADR_W*k +: ADR_W]),
            .radr    (req.REQ_RADR[ADR_W*k +: ADR_W]),
            .wdat    (req.REQ_WDAT[DAT_W*k +: DAT_W]),
            .wr_take (wr_take_s[k]),
            .rd_take (rd_take_s[k]),
            .wfull   (wfull_s[k]),
            .rfull   (rfull_s[k]),
            .wadr_q  (slot_wadr_s[k]),
            .radr_q  (slot_radr_s[k]),
            .wdat_q  (slot_wdat_s[k]),
            .ovf     (ovf_s[k])
        );
    end

    // Counter is one step from TIMEOUT-1, so this edge ends the wait
    assign to_last_s = (to_cnt_r == CNT_W'(TIMEOUT - 2));

    // Round-robin search for the first master with a pending slot
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_wr_s    = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = IDX_W'(wrap_add(32'(ptr_r), 32'(i), 32'(N_REQ)));
            if (!sel_found_s && (wfull_s[cand_s] || rfull_s[cand_s])) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
                sel_wr_s    = wfull_s[cand_s];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state logic and slot consume strobes
    always_comb begin
        state_nxt_s = state_r;
        wr_take_s   = '0;
        rd_take_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s && sel_wr_s) begin
                    state_nxt_s          = ST_ISSUE_WR;
                    wr_take_s[sel_idx_s] = 1'b1;
                end else if (sel_found_s) begin
                    state_nxt_s          = ST_ISSUE_RD;
                    rd_take_s[sel_idx_s] = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE_WR: state_nxt_s = ST_IDLE;
            ST_ISSUE_RD: state_nxt_s = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (m.M_RVLD || to_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pointer, downstream bus registers, timeout and response demux
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            gnt_r     <= '0;
            to_cnt_r  <= '0;
            m_wren_r  <= 1'b0;
            m_rden_r  <= 1'b0;
            m_wadr_r  <= '0;
            m_radr_r  <= '0;
            m_wdat_r  <= '0;
            rvld_r    <= '0;
            to_stky_r <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                rdat_r[i] <= '0;
            end
        end else begin
            state_r  <= state_nxt_s;
            m_wren_r <= (state_nxt_s == ST_ISSUE_WR);
            m_rden_r <= (state_nxt_s == ST_ISSUE_RD);
            rvld_r   <= '0;
            if (state_r == ST_IDLE && sel_found_s) begin
                gnt_r <= sel_idx_s;
                ptr_r <= IDX_W'(wrap_add(32'(sel_idx_s), 32'd1, 32'(N_REQ)));
                if (sel_wr_s) begin
                    m_wadr_r <= slot_wadr_s[sel_idx_s];
                    m_wdat_r <= slot_wdat_s[sel_idx_s];
                end else begin
                    m_radr_r <= slot_radr_s[sel_idx_s];
                end
            end
            if (state_r == ST_ISSUE_RD) begin
                to_cnt_r <= '0;
            end else if (state_r == ST_WAIT_RD) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1);
            end
            // A response arriving on the timeout edge still wins
            if (state_r == ST_WAIT_RD) begin
                if (m.M_RVLD) begin
                    rdat_r[gnt_r] <= m.M_RDAT;
                    rvld_r[gnt_r] <= 1'b1;
                end else if (to_last_s) begin
                    rdat_r[gnt_r] <= TO_DATA;
                    rvld_r[gnt_r] <= 1'b1;
                    to_stky_r     <= 1'b1;
                end
            end
        end
    end

    // Pack per-master read data onto the upstream bus
    always_comb begin
        rdat_pk_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rdat_pk_s[DAT_W*i +: DAT_W] = rdat_r[i];
        end
    end

    assign m.M_WREN      = m_wren_r;
    assign m.M_RDEN      = m_rden_r;
    assign m.M_WADR      = m_wadr_r;
    assign m.M_RADR      = m_radr_r;
    assign m.M_WDAT      = m_wdat_r;
    assign req.REQ_RDAT  = rdat_pk_s;
    assign req.REQ_RVLD  = rvld_r;
    assign req.REQ_WBUSY = wfull_s;
    assign req.REQ_RBUSY = rfull_s;
    assign OVF_STKY      = ovf_s;
    assign TO_STKY       = to_stky_r;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed self-checking bench for reg_bus_arb (N_REQ=2, TIMEOUT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_bus_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ovf_stky;
    logic       to_stky;
    int         errors = 0;
    int         checks = 0;

    reg_bus_req_if #(.N_REQ(2)) req_if ();
    reg_bus_m_if                m_if ();

    reg_bus_arb #(.N_REQ(2), .TIMEOUT(8), .TO_DATA(32'hDEAD_BEEF)) dut (
        .CLK      (clk),
        .RST      (rst),
        .req      (req_if),
        .m        (m_if),
        .OVF_STKY (ovf_stky),
        .TO_STKY  (to_stky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_if.M_WREN, m_if.M_RDEN, m_if.M_WADR, m_if.M_RADR, m_if.M_WDAT} !== '0) begin
            errors++; $display("FAIL reset_mbus: got %h required 0", {m_if.M_WADR, m_if.M_RADR, m_if.M_WDAT});
        end
        checks++;
        if ({req_if.REQ_RDAT, req_if.REQ_RVLD, req_if.REQ_WBUSY, req_if.REQ_RBUSY, ovf_stky, to_stky} !== '0) begin
            errors++; $display("FAIL reset_req: rdat=%h rvld=%b wb=%b rb=%b ovf=%b to=%b required all 0",
                req_if.REQ_RDAT, req_if.REQ_RVLD, req_if.REQ_WBUSY, req_if.REQ_RBUSY, ovf_stky, to_stky);
        end
    endtask

    task automatic test_single_write();
        req_if.REQ_WADR[31:0] = 32'h0000_0104;
        req_if.REQ_WDAT[31:0] = 32'h1234_5678;
        req_if.REQ_WREN = 2'b01;
        tick();
        req_if.REQ_WREN = 2'b00;
        checks++;
        if (req_if.REQ_WBUSY !== 2'b01) begin
            errors++; $display("FAIL sw_busy_t1: got %b required 01", req_if.REQ_WBUSY);
        end
        checks++;
        if (m_if.M_WREN !== 1'b0) begin
            errors++; $display("FAIL sw_early_wren: got %b required 0", m_if.M_WREN);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b1 || m_if.M_WADR !== 32'h0000_0104 || m_if.M_WDAT !== 32'h1234_5678) begin
            errors++; $display("FAIL sw_issue: wren=%b adr=%h dat=%h required 1 00000104 12345678",
                m_if.M_WREN, m_if.M_WADR, m_if.M_WDAT);
        end
        checks++;
        if (req_if.REQ_WBUSY !== 2'b00) begin
            errors++; $display("FAIL sw_busy_t2: got %b required 00", req_if.REQ_WBUSY);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b0 || m_if.M_WADR !== 32'h0000_0104) begin
            errors++; $display("FAIL sw_after: wren=%b adr=%h required 0 00000104", m_if.M_WREN, m_if.M_WADR);
        end
    endtask

    task automatic test_simul_writes();
        do_reset();
        req_if.REQ_WADR = {32'h0000_0200, 32'h0000_0100};
        req_if.REQ_WDAT = {32'hBBBB_0002, 32'hAAAA_0001};
        req_if.REQ_WREN = 2'b11;
        tick();
        req_if.REQ_WREN = 2'b00;
        checks++;
        if (req_if.REQ_WBUSY !== 2'b11) begin
            errors++; $display("FAIL sim_busy: got %b required 11", req_if.REQ_WBUSY);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b1 || m_if.M_WADR !== 32'h0000_0100 || m_if.M_WDAT !== 32'hAAAA_0001) begin
            errors++; $display("FAIL sim_first: wren=%b adr=%h dat=%h required 1 00000100 aaaa0001",
                m_if.M_WREN, m_if.M_WADR, m_if.M_WDAT);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b0) begin
            errors++; $display("FAIL sim_gap: got %b required 0", m_if.M_WREN);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b1 || m_if.M_WADR !== 32'h0000_0200 || m_if.M_WDAT !== 32'hBBBB_0002) begin
            errors++; $display("FAIL sim_second: wren=%b adr=%h dat=%h required 1 00000200 bbbb0002",
                m_if.M_WREN, m_if.M_WADR, m_if.M_WDAT);
        end
        checks++;
        if (ovf_stky !== 2'b00) begin
            errors++; $display("FAIL sim_ovf: got %b required 00", ovf_stky);
        end
        tick();
    endtask

    task automatic test_read_routing();
        req_if.REQ_RADR[63:32] = 32'h0000_0304;
        req_if.REQ_RDEN = 2'b10;
        tick();
        req_if.REQ_RDEN = 2'b00;
        checks++;
        if (req_if.REQ_RBUSY !== 2'b10) begin
            errors++; $display("FAIL rd_busy: got %b required 10", req_if.REQ_RBUSY);
        end
        tick();
        checks++;
        if (m_if.M_RDEN !== 1'b1 || m_if.M_RADR !== 32'h0000_0304) begin
            errors++; $display("FAIL rd_issue: rden=%b adr=%h required 1 00000304", m_if.M_RDEN, m_if.M_RADR);
        end
        tick();
        tick();
        checks++;
        if (req_if.REQ_RVLD !== 2'b00 || m_if.M_RDEN !== 1'b0) begin
            errors++; $display("FAIL rd_wait: rvld=%b rden=%b required 00 0", req_if.REQ_RVLD, m_if.M_RDEN);
        end
        tick();
        m_if.M_RDAT = 32'hCAFE_0001;
        m_if.M_RVLD = 1'b1;
        tick();
        m_if.M_RVLD = 1'b0;
        m_if.M_RDAT = 32'h0;
        checks++;
        if (req_if.REQ_RVLD !== 2'b10 || req_if.REQ_RDAT[63:32] !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rd_resp: rvld=%b rdat1=%h required 10 cafe0001",
                req_if.REQ_RVLD, req_if.REQ_RDAT[63:32]);
        end
        tick();
        checks++;
        if (req_if.REQ_RVLD !== 2'b00 || req_if.REQ_RDAT[63:32] !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rd_hold: rvld=%b rdat1=%h required 00 cafe0001",
                req_if.REQ_RVLD, req_if.REQ_RDAT[63:32]);
        end
    endtask

    task automatic test_timeout();
        int early_rvld;
        early_rvld = 0;
        req_if.REQ_RADR[31:0] = 32'h0000_0500;
        req_if.REQ_RDEN = 2'b01;
        tick();
        req_if.REQ_RDEN = 2'b00;
        tick();
        checks++;
        if (m_if.M_RDEN !== 1'b1 || m_if.M_RADR !== 32'h0000_0500) begin
            errors++; $display("FAIL to_issue: rden=%b adr=%h required 1 00000500", m_if.M_RDEN, m_if.M_RADR);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (req_if.REQ_RVLD !== 2'b00) early_rvld++;
        end
        checks++;
        if (early_rvld != 0) begin
            errors++; $display("FAIL to_early: got %0d early rvld cycles required 0", early_rvld);
        end
        tick();
        checks++;
        if (req_if.REQ_RVLD !== 2'b01 || req_if.REQ_RDAT[31:0] !== 32'hDEAD_BEEF || to_stky !== 1'b1) begin
            errors++; $display("FAIL to_resp: rvld=%b rdat0=%h to=%b required 01 deadbeef 1",
                req_if.REQ_RVLD, req_if.REQ_RDAT[31:0], to_stky);
        end
        checks++;
        if (req_if.REQ_RDAT[63:32] !== 32'hCAFE_0001) begin
            errors++; $display("FAIL to_other_hold: got %h required cafe0001", req_if.REQ_RDAT[63:32]);
        end
        req_if.REQ_WADR[63:32] = 32'h0000_0700;
        req_if.REQ_WREN = 2'b10;
        tick();
        req_if.REQ_WREN = 2'b00;
        m_if.M_RVLD = 1'b1;
        m_if.M_RDAT = 32'h5555_5555;
        tick();
        m_if.M_RVLD = 1'b0;
        checks++;
        if (m_if.M_WREN !== 1'b1 || m_if.M_WADR !== 32'h0000_0700) begin
            errors++; $display("FAIL to_later_wr: wren=%b adr=%h required 1 00000700", m_if.M_WREN, m_if.M_WADR);
        end
        checks++;
        if (req_if.REQ_RVLD !== 2'b00 || req_if.REQ_RDAT[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL stray_rvld: rvld=%b rdat0=%h required 00 deadbeef",
                req_if.REQ_RVLD, req_if.REQ_RDAT[31:0]);
        end
        tick();
    endtask

    task automatic test_overflow();
        req_if.REQ_RADR[63:32] = 32'h0000_0900;
        req_if.REQ_RDEN = 2'b10;
        tick();
        req_if.REQ_RDEN = 2'b00;
        tick();
        tick();
        checks++;
        if (ovf_stky !== 2'b00) begin
            errors++; $display("FAIL ovf_pre: got %b required 00", ovf_stky);
        end
        req_if.REQ_WREN = 2'b01;
        req_if.REQ_WADR[31:0] = 32'h0000_0A00;
        tick();
        req_if.REQ_WADR[31:0] = 32'h0000_0A04;
        tick();
        req_if.REQ_WADR[31:0] = 32'h0000_0A08;
        tick();
        req_if.REQ_WREN = 2'b00;
        checks++;
        if (ovf_stky !== 2'b01 || req_if.REQ_WBUSY !== 2'b01) begin
            errors++; $display("FAIL ovf_flag: ovf=%b wbusy=%b required 01 01", ovf_stky, req_if.REQ_WBUSY);
        end
        m_if.M_RDAT = 32'h1111_2222;
        m_if.M_RVLD = 1'b1;
        tick();
        m_if.M_RVLD = 1'b0;
        checks++;
        if (req_if.REQ_RVLD !== 2'b10 || req_if.REQ_RDAT[63:32] !== 32'h1111_2222) begin
            errors++; $display("FAIL ovf_rd_resp: rvld=%b rdat1=%h required 10 11112222",
                req_if.REQ_RVLD, req_if.REQ_RDAT[63:32]);
        end
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b1 || m_if.M_WADR !== 32'h0000_0A00) begin
            errors++; $display("FAIL ovf_kept: wren=%b adr=%h required 1 00000a00", m_if.M_WREN, m_if.M_WADR);
        end
        tick();
        tick();
        checks++;
        if (m_if.M_WREN !== 1'b0 || req_if.REQ_WBUSY !== 2'b00) begin
            errors++; $display("FAIL ovf_no_extra: wren=%b wbusy=%b required 0 00", m_if.M_WREN, req_if.REQ_WBUSY);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_seq [4];
        logic [31:0] got_seq [4];
        int          n_issue;
        exp_seq = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
        got_seq = '{32'h0, 32'h0, 32'h0, 32'h0};
        n_issue = 0;
        do_reset();
        req_if.REQ_WADR = {32'h0000_2000, 32'h0000_1000};
        req_if.REQ_WREN = 2'b11;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (m_if.M_WREN === 1'b1) begin
                if (n_issue < 4) got_seq[n_issue] = m_if.M_WADR;
                n_issue++;
            end
        end
        req_if.REQ_WREN = 2'b00;
        checks++;
        if (n_issue != 4) begin
            errors++; $display("FAIL rr_count: got %0d issues required 4", n_issue);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got %h required %h", i, got_seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int stray;
        stray = 0;
        do_reset();
        req_if.REQ_RADR[31:0] = 32'h0000_0B00;
        req_if.REQ_WADR = {32'h0000_0C00, 32'h0000_0D00};
        req_if.REQ_RDEN = 2'b01;
        tick();
        req_if.REQ_RDEN = 2'b00;
        tick();
        tick();
        checks++;
        if (m_if.M_RDEN !== 1'b0 || m_if.M_RADR !== 32'h0000_0B00) begin
            errors++; $display("FAIL rst_rd_setup: rden=%b adr=%h required 0 00000b00", m_if.M_RDEN, m_if.M_RADR);
        end
        req_if.REQ_WREN = 2'b10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_if.REQ_WREN = 2'b00;
        checks++;
        if ({m_if.M_WREN, m_if.M_RDEN, m_if.M_WADR, m_if.M_RADR, m_if.M_WDAT, req_if.REQ_RDAT,
             req_if.REQ_RVLD, req_if.REQ_WBUSY, req_if.REQ_RBUSY, ovf_stky, to_stky} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: radr=%h wadr=%h rdat=%h wb=%b ovf=%b required all 0",
                m_if.M_RADR, m_if.M_WADR, req_if.REQ_RDAT, req_if.REQ_WBUSY, ovf_stky);
        end
        m_if.M_RDAT = 32'h7777_7777;
        m_if.M_RVLD = 1'b1;
        tick();
        m_if.M_RVLD = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (req_if.REQ_RVLD !== 2'b00 || m_if.M_RDEN !== 1'b0 || m_if.M_WREN !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rst_no_rvld: got %0d cycles with activity required 0", stray);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_if.REQ_WREN = 2'b00;
        req_if.REQ_RDEN = 2'b00;
        req_if.REQ_WADR = '0;
        req_if.REQ_RADR = '0;
        req_if.REQ_WDAT = '0;
        m_if.M_RDAT = 32'h0;
        m_if.M_RVLD = 1'b0;
        test_reset();
        test_single_write();
        test_simul_writes();
        test_read_routing();
        test_timeout();
        test_overflow();
        test_round_robin();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
